// File: rtl/byte_mem_dumper.sv
// Dumps a range of the byte memory into the word memory as {addr, data} words.
// Latency: 3 cycles per entry (RD, CAP, WR); done pulses in cycle 3N+1 after start (cycle 1 if N = 0).
// Backpressure: none; both memories are fixed-latency, and start is only honoured in IDLE.
module byte_mem_dumper #(
   parameter int BAW   = 8,
   parameter int WAW   = 16,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BAW-1:0]   src_base,
   input  logic [WAW-1:0]   dst_base,
   input  logic [CNT_W-1:0] count,
   output logic             b_rw,
   output logic [BAW-1:0]   b_add,
   input  logic [7:0]       b_data,
   output logic             w_rw,
   output logic [WAW-1:0]   w_add,
   output logic [15:0]      w_data,
   output logic             busy,
   output logic             done,
   output logic [2:0]       fsm_tb
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [BAW-1:0]   src, src_nxt;
   logic [WAW-1:0]   dst, dst_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [BAW-1:0]   b_add_nxt;
   logic [WAW-1:0]   w_add_nxt;
   logic [15:0]      w_data_nxt;
   logic             w_rw_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // The byte memory is only ever read.
   assign b_rw   = 1'b1;
   assign fsm_tb = state;

   // Next-state, pointer updates and next output values; outputs are decoded
   // from the state being entered so they are registered and stable all state.
   always_comb begin
      state_nxt  = state;
      src_nxt    = src;
      dst_nxt    = dst;
      cnt_nxt    = cnt;
      b_add_nxt  = b_add;
      w_add_nxt  = w_add;
      w_data_nxt = w_data;

      case (state)
         IDLE: begin
            if (start) begin
               src_nxt = src_base;
               dst_nxt = dst_base;
               cnt_nxt = count;
               if (count == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RD;
                  b_add_nxt = src_base;
               end
            end
         end
         RD: begin
            // b_add is sampled by the memory at the end of this cycle.
            state_nxt = CAP;
         end
         CAP: begin
            // b_data is valid now; latch the packed word so later b_data
            // changes cannot leak into the write.
            state_nxt  = WR;
            w_data_nxt = 16'({src, b_data});
            w_add_nxt  = dst;
         end
         WR: begin
            src_nxt = src + BAW'(1);
            dst_nxt = dst + WAW'(1);
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RD;
               b_add_nxt = src + BAW'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt == RD) || (state_nxt == CAP) || (state_nxt == WR);
      done_nxt = (state_nxt == DONE);
      w_rw_nxt = (state_nxt != WR);
   end

   // State, working pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         src    <= '0;
         dst    <= '0;
         cnt    <= '0;
         b_add  <= '0;
         w_rw   <= 1'b1;
         w_add  <= '0;
         w_data <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         src    <= src_nxt;
         dst    <= dst_nxt;
         cnt    <= cnt_nxt;
         b_add  <= b_add_nxt;
         w_rw   <= w_rw_nxt;
         w_add  <= w_add_nxt;
         w_data <= w_data_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_byte_mem_dumper.sv
// Self-checking bench for byte_mem_dumper with behavioural byte and word memories.
// Latency: expectations derived from 3 cycles per entry, done in cycle 3N+1.
// Backpressure: none; the bench only drives start/rst and observes.
module tb_byte_mem_dumper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  src_base = '0;
   logic [15:0] dst_base = '0;
   logic [8:0]  count = '0;
   logic        b_rw;
   logic [7:0]  b_add;
   logic [7:0]  b_data = '0;
   logic        w_rw;
   logic [15:0] w_add;
   logic [15:0] w_data;
   logic        busy;
   logic        done;
   logic [2:0]  fsm_tb;

   byte_mem_dumper #(.BAW(8), .WAW(16), .CNT_W(9)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_base(src_base), .dst_base(dst_base), .count(count),
      .b_rw(b_rw), .b_add(b_add), .b_data(b_data),
      .w_rw(w_rw), .w_add(w_add), .w_data(w_data),
      .busy(busy), .done(done), .fsm_tb(fsm_tb)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem8  [256];
   logic [7:0]  mem8_save [256];
   logic [15:0] mem16 [65536];

   // Byte memory: registered read port.
   always @(posedge clk) b_data <= mem8[b_add];
   // Word memory: write when rw is low.
   always @(posedge clk) if (w_rw === 1'b0) mem16[w_add] <= w_data;

   int gcyc = 0;
   always @(posedge clk) gcyc <= gcyc + 1;

   // Observation log, sampled mid-cycle.
   int wq_cyc[$];
   logic [15:0] wq_add[$];
   logic [15:0] wq_dat[$];
   int dq[$];
   int busy_cnt, consec_err, brw_err;
   bit prev_w = 0;

   always @(negedge clk) begin
      if (w_rw === 1'b0) begin
         wq_cyc.push_back(gcyc);
         wq_add.push_back(w_add);
         wq_dat.push_back(w_data);
         if (prev_w) consec_err++;
      end
      prev_w = (w_rw === 1'b0);
      if (done === 1'b1) dq.push_back(gcyc);
      if (busy === 1'b1) busy_cnt++;
      if (b_rw !== 1'b1) brw_err++;
   end

   int tests = 0;
   int failed = 0;
   int g0 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wq_cyc.delete(); wq_add.delete(); wq_dat.delete(); dq.delete();
      busy_cnt = 0; consec_err = 0; brw_err = 0;
   endtask

   // Present a one-cycle start; afterwards the bench sits in cycle 1.
   task automatic launch(input logic [7:0] s, input logic [15:0] d, input logic [8:0] c);
      @(negedge clk);
      clear_log();
      src_base = s; dst_base = d; count = c; start = 1'b1;
      @(posedge clk); #1;
      g0 = gcyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (dq.size() > 0) begin ok = 1; break; end
         @(negedge clk); #1;
      end
      check("done_seen", 64'(ok), 64'd1);
      repeat (4) begin @(negedge clk); #1; end
   endtask

   // Reference: entry i reads byte (s+i) mod 256, writes word (d+i) mod 65536
   // in cycle 3(i+1); N entries keep busy high 3N cycles.
   task automatic verify(input logic [7:0] s, input logic [15:0] d, input int c, input int exp_done);
      int n;
      logic [7:0] sa;
      check("done_pulses", 64'(dq.size()), 64'd1);
      if (dq.size() > 0) check("done_cycle", 64'(dq[0] - g0 + 1), 64'(exp_done));
      check("n_writes", 64'(wq_add.size()), 64'(c));
      n = (wq_add.size() < c) ? wq_add.size() : c;
      for (int i = 0; i < n; i++) begin
         sa = s + 8'(i);
         check("write", {16'(wq_cyc[i] - g0 + 1), wq_add[i], wq_dat[i]},
               {16'(3 * (i + 1)), 16'(d + 16'(i)), sa, mem8[sa]});
      end
      check("consec_wr", 64'(consec_err), 64'd0);
      check("b_rw_read", 64'(brw_err), 64'd0);
      check("busy_len", 64'(busy_cnt), 64'(3 * c));
   endtask

   typedef struct {
      logic [7:0]  src;
      logic [15:0] dst;
      logic [8:0]  cnt;
      int          exp_done;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int c;
      logic [7:0]  s;
      logic [15:0] d;
      logic [15:0] wd;
      int bad;

      vecs[0] = '{8'h10, 16'h0200, 9'd3,   10};
      vecs[1] = '{8'h40, 16'h0300, 9'd0,   1};
      vecs[2] = '{8'hFE, 16'hFFFF, 9'd3,   10};
      vecs[3] = '{8'h7F, 16'h0010, 9'd1,   4};
      vecs[4] = '{8'h80, 16'h1000, 9'd256, 769};

      for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
      for (int i = 0; i < 65536; i++) mem16[i] = '0;
      mem8[8'h10] = 8'hA1; mem8[8'h11] = 8'hB2; mem8[8'h12] = 8'hC3;
      mem8[8'hFE] = 8'h11; mem8[8'hFF] = 8'h22; mem8[8'h00] = 8'h33;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_b_rw",   64'(b_rw),   64'd1);
      check("rst_b_add",  64'(b_add),  64'd0);
      check("rst_w_rw",   64'(w_rw),   64'd1);
      check("rst_w_add",  64'(w_add),  64'd0);
      check("rst_w_data", 64'(w_data), 64'd0);
      check("rst_busy",   64'(busy),   64'd0);
      check("rst_done",   64'(done),   64'd0);
      check("rst_fsm",    64'(fsm_tb), 64'd0);
      rst = 1'b0;

      // Table-driven runs
      for (int v = 0; v < 5; v++) begin
         launch(vecs[v].src, vecs[v].dst, vecs[v].cnt);
         wait_done(1000);
         verify(vecs[v].src, vecs[v].dst, int'(vecs[v].cnt), vecs[v].exp_done);
      end
      check("mem16_0200", 64'(mem16[16'h0200]), 64'h10A1);
      check("mem16_0201", 64'(mem16[16'h0201]), 64'h11B2);
      check("mem16_0202", 64'(mem16[16'h0202]), 64'h12C3);
      check("mem16_FFFF", 64'(mem16[16'hFFFF]), 64'hFE11);
      check("mem16_0000", 64'(mem16[16'h0000]), 64'hFF22);
      check("mem16_0001", 64'(mem16[16'h0001]), 64'h0033);

      // Round trip: unpack the 256-entry dump into a cleared byte memory.
      for (int i = 0; i < 256; i++) begin mem8_save[i] = mem8[i]; mem8[i] = '0; end
      for (int i = 0; i < 256; i++) begin
         wd = mem16[16'h1000 + 16'(i)];
         mem8[wd[15:8]] = wd[7:0];
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem8[i] !== mem8_save[i]) bad++;
      check("round_trip_mismatches", 64'(bad), 64'd0);

      // Randomized runs against the reference
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
         s = 8'($urandom);
         d = 16'($urandom);
         c = $urandom_range(0, 12);
         launch(s, d, 9'(c));
         wait_done(200);
         verify(s, d, c, (c == 0) ? 1 : 3 * c + 1);
      end

      // Reset during the second CAP of a 4-entry run
      launch(8'h20, 16'h0500, 9'd4);
      repeat (4) @(posedge clk);
      #1;
      check("mid_rst_in_cap", 64'(fsm_tb), 64'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_fsm",  64'(fsm_tb), 64'd0);
      check("mid_rst_w_rw", 64'(w_rw),   64'd1);
      check("mid_rst_busy", 64'(busy),   64'd0);
      rst = 1'b0;
      repeat (12) begin @(negedge clk); #1; end
      check("mid_rst_writes", 64'(wq_add.size()), 64'd1);
      check("mid_rst_dones",  64'(dq.size()),     64'd0);

      // Start pulses while busy and in DONE are ignored
      for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
      launch(8'h30, 16'h0600, 9'd2);
      @(posedge clk); #1;
      src_base = 8'h99; dst_base = 16'h0900; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         bit ok = 0;
         for (int i = 0; i < 50; i++) begin
            if (dq.size() > 0) begin ok = 1; break; end
            @(negedge clk); #1;
         end
         check("busy_start_done_seen", 64'(ok), 64'd1);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(negedge clk); #1; end
      verify(8'h30, 16'h0600, 2, 7);

      // Start held high re-triggers from IDLE
      launch(8'h50, 16'h0700, 9'd1);
      start = 1'b1;
      begin
         bit ok = 0;
         for (int i = 0; i < 50; i++) begin
            if (dq.size() >= 2) begin ok = 1; break; end
            @(negedge clk); #1;
         end
         check("held_two_dones", 64'(ok), 64'd1);
      end
      start = 1'b0;
      repeat (10) begin @(negedge clk); #1; end
      check("held_done_count", 64'(dq.size()), 64'd2);
      if (dq.size() >= 2) begin
         check("held_done1_cyc", 64'(dq[0] - g0 + 1), 64'd4);
         check("held_done2_cyc", 64'(dq[1] - g0 + 1), 64'd9);
      end
      check("held_writes", 64'(wq_add.size()), 64'd2);
      if (wq_add.size() >= 2) begin
         check("held_wr2", {16'(wq_cyc[1] - g0 + 1), wq_add[1], wq_dat[1]},
               {16'd8, 16'h0700, 8'h50, mem8[8'h50]});
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
